player_press_conditioner: RTL and testbench

- Front end of the tug-of-war playfield: conditions the two raw player buttons into clean, single-press requests.
- Feeds the turnOn/turnOff inputs of the light chain. press_l drives the left-pull direction and press_r the right-pull direction.
- Synchronises and debounces each button, and converts each press into one request. The request is held until a CE cycle consumes it.
- Simultaneous presses in the same CE window cancel each other.

---
 rtl/player_press_conditioner_if.sv | 20 ++
 rtl/player_press_conditioner.sv | 125 ++++++++++++
 tb/tb_player_press_conditioner.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/player_press_conditioner_if.sv
// Bundles the tick, enable, raw buttons and request outputs of the press conditioner.
// With PRESS_COUNT_EN defined, it also carries the delivered-press counters.
interface player_press_conditioner_if;
   logic       CE;
   logic       enable;
   logic       btn_l;
   logic       btn_r;
   logic       press_l;
   logic       press_r;
`ifdef PRESS_COUNT_EN
   logic [7:0] count_l;
   logic [7:0] count_r;

   modport master (output CE, enable, btn_l, btn_r, input press_l, press_r, count_l, count_r);
   modport slave  (input CE, enable, btn_l, btn_r, output press_l, press_r, count_l, count_r);
`else
   modport master (output CE, enable, btn_l, btn_r, input press_l, press_r);
   modport slave  (input CE, enable, btn_l, btn_r, output press_l, press_r);
`endif
endinterface

// File: rtl/player_press_conditioner.sv
// Turns two raw player buttons into clean single-press pull requests for the light chain.
// Optional macro PRESS_COUNT_EN adds saturating 8-bit counters of the requests delivered.
module player_press_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SYNC_STAGES     = 2
) (
   input logic                        clk,
   input logic                        reset_n,
   player_press_conditioner_if.slave  bus
);

   localparam int            CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam int            SW        = $clog2(SYNC_STAGES + 1);
   localparam logic [SW-1:0] SYNC_FILL = SW'(SYNC_STAGES);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESSED = 1'b1;

   // Index 0 is the left player, index 1 the right player.
   logic [1:0]             btnRaw;
   logic [SYNC_STAGES-1:0] syncChain_q [2];
   logic [SYNC_STAGES-1:0] syncChain_d [2];
   logic [1:0]             syncLvl;
   logic [CW-1:0]          dbCnt_q [2];
   logic [CW-1:0]          dbCnt_d [2];
   logic [1:0]             stable_q, stable_d;
   logic [1:0]             stablePrev_q, stablePrev_d;
   logic [1:0]             armed_q, armed_d;
   logic [1:0]             pend_q, pend_d;
   logic [SW-1:0]          startCnt_q, startCnt_d;
   logic                   startDone;
   logic [1:0]             pressEdge;
   logic [1:0]             deliver;

   assign btnRaw    = {bus.btn_r, bus.btn_l};
   assign startDone = (startCnt_q == SYNC_FILL);

   // A button only arms once the synchroniser has flushed its reset zeros and shows it released,
   // so a button held through reset never counts as a press.
   always_comb begin
      startCnt_d   = startCnt_q;
      stablePrev_d = stable_q;
      if (!startDone) begin
         startCnt_d = startCnt_q + 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         syncChain_d[i] = {syncChain_q[i][SYNC_STAGES-2:0], btnRaw[i]};
         syncLvl[i]     = syncChain_q[i][SYNC_STAGES-1];
         stable_d[i]    = stable_q[i];
         dbCnt_d[i]     = '0;
         if (syncLvl[i] != stable_q[i]) begin
            if (dbCnt_q[i] == DB_LAST) begin
               stable_d[i] = syncLvl[i];
            end else begin
               dbCnt_d[i] = dbCnt_q[i] + 1'b1;
            end
         end
         armed_d[i]   = armed_q[i] | (startDone & ~syncLvl[i]);
         pressEdge[i] = (stable_q[i] == ST_PRESSED) && (stablePrev_q[i] == ST_IDLE)
                        && armed_q[i] && bus.enable;
         pend_d[i]    = pressEdge[i] | (pend_q[i] & ~bus.CE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            syncChain_q[i] <= '0;
            dbCnt_q[i]     <= '0;
         end
         stable_q     <= '0;
         stablePrev_q <= '0;
         armed_q      <= '0;
         pend_q       <= '0;
         startCnt_q   <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            syncChain_q[i] <= syncChain_d[i];
            dbCnt_q[i]     <= dbCnt_d[i];
         end
         stable_q     <= stable_d;
         stablePrev_q <= stablePrev_d;
         armed_q      <= armed_d;
         pend_q       <= pend_d;
         startCnt_q   <= startCnt_d;
      end
   end

   // Both pending at once is a tie: neither side is delivered.
   assign deliver[0]  = pend_q[0] & ~pend_q[1];
   assign deliver[1]  = pend_q[1] & ~pend_q[0];
   assign bus.press_l = deliver[0];
   assign bus.press_r = deliver[1];

`ifdef PRESS_COUNT_EN
   logic [7:0] count_q [2];
   logic [7:0] count_d [2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         count_d[i] = count_q[i];
         if (bus.CE && deliver[i] && (count_q[i] != 8'hFF)) begin
            count_d[i] = count_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            count_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            count_q[i] <= count_d[i];
         end
      end
   end

   assign bus.count_l = count_q[0];
   assign bus.count_r = count_q[1];
`endif

endmodule

// File: tb/tb_player_press_conditioner.sv
// Directed, table-driven bench for player_press_conditioner at the default parameters.
// Define PRESS_COUNT_EN to also exercise the saturating press counters.
module tb_player_press_conditioner;

   typedef struct {
      logic btnL;
      logic btnR;
      logic enable;
      logic ce;
      int   cycles;
      logic expL;
      logic expR;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   compared   = 0;
   int   mismatched = 0;
   vec_t vecs[$];

   player_press_conditioner_if bus ();

   player_press_conditioner #(
      .DEBOUNCE_CYCLES (16),
      .SYNC_STAGES     (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic bl, input logic br, input logic en, input logic ce,
                               input int cyc, input logic el, input logic er);
      vec_t v;
      v.btnL = bl; v.btnR = br; v.enable = en; v.ce = ce;
      v.cycles = cyc; v.expL = el; v.expR = er;
      return v;
   endfunction

   // Inputs change just after a falling edge; outputs are sampled on a later falling edge.
   task automatic applyStimulus(input vec_t v);
      bus.btn_l  = v.btnL;
      bus.btn_r  = v.btnR;
      bus.enable = v.enable;
      bus.CE     = v.ce;
      repeat (v.cycles) @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic resetDut(input logic holdL);
      bus.btn_l  = holdL;
      bus.btn_r  = 1'b0;
      bus.enable = 1'b1;
      bus.CE     = 1'b0;
      reset_n    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("reset_press_l_%0d", i), int'(bus.press_l), 0);
         checkOutput($sformatf("reset_press_r_%0d", i), int'(bus.press_r), 0);
      end
      reset_n = 1'b1;
   endtask

   initial begin
      int bad;
      int rises;
      int lat;
      logic prevR;

      bus.btn_l  = 1'b0;
      bus.btn_r  = 1'b0;
      bus.enable = 1'b1;
      bus.CE     = 1'b0;
      reset_n    = 1'b0;

      // Button held through reset must not produce a request.
      resetDut(1'b1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.press_l || bus.press_r) bad++;
      end
      checkOutput("held_through_reset", bad, 0);
      bus.btn_l = 1'b0;
      idleCycles(25);

      // Fields: btnL, btnR, enable, ce, cycles, expL, expR
      // Clean left press, consume, hold, release
      vecs.push_back(mk(1, 0, 1, 0, 18, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0,  1, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 10, 1, 0));
      vecs.push_back(mk(1, 0, 1, 1,  1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 40, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 30, 0, 0));
      // Clean right press
      vecs.push_back(mk(0, 1, 1, 0, 19, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1,  1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 30, 0, 0));
      // Press while disabled is ignored
      vecs.push_back(mk(1, 0, 0, 0, 25, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 25, 0, 0));
      // Press queued, then enable drops, still drains on CE
      vecs.push_back(mk(1, 0, 1, 0, 19, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0,  5, 1, 0));
      vecs.push_back(mk(1, 0, 0, 1,  1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 25, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, 0, 0));
      // Two presses in one CE window collapse to one request
      vecs.push_back(mk(1, 0, 1, 0, 19, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 25, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 19, 1, 0));
      vecs.push_back(mk(1, 0, 1, 1,  1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 25, 0, 0));
      // Tie: left then right 3 cycles later, cancelled by CE
      vecs.push_back(mk(1, 0, 1, 0,  3, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 19, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 10, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1,  1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 25, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 19, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1,  1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 25, 0, 0));
      // Press edge coinciding with CE survives into the next tick
      vecs.push_back(mk(1, 0, 1, 0, 18, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1,  1, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0,  5, 1, 0));
      vecs.push_back(mk(1, 0, 1, 1,  1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 25, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_press_l", i), int'(bus.press_l), int'(vecs[i].expL));
         checkOutput($sformatf("vec%0d_press_r", i), int'(bus.press_r), int'(vecs[i].expR));
      end

      // Bouncing right button: toggles every 5 cycles, then settles high.
      rises = 0;
      lat   = -1;
      prevR = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if (t % 5 == 0) bus.btn_r = ~bus.btn_r;
         @(negedge clk);
         if (bus.press_r && !prevR) rises++;
         prevR = bus.press_r;
      end
      bus.btn_r = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.press_r && !prevR) begin
            rises++;
            if (lat < 0) lat = k;
         end
         prevR = bus.press_r;
      end
      checkOutput("bounce_press_count", rises, 1);
      checkOutput("bounce_latency_in_18_19", int'(lat >= 18 && lat <= 19), 1);
      applyStimulus(mk(1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0));
      applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b0, 25, 1'b0, 1'b0));
      checkOutput("bounce_consumed", int'(bus.press_r), 0);

      // Asynchronous reset clears a pending request without waiting for a clock edge.
      applyStimulus(mk(1'b1, 1'b0, 1'b1, 1'b0, 19, 1'b1, 1'b0));
      checkOutput("pre_async_reset_press_l", int'(bus.press_l), 1);
      #2 reset_n = 1'b0;
      #1 checkOutput("async_reset_press_l", int'(bus.press_l), 0);
      @(negedge clk);
      bus.btn_l = 1'b0;
      reset_n   = 1'b1;
      idleCycles(25);

`ifdef PRESS_COUNT_EN
      resetDut(1'b0);
      idleCycles(5);
      checkOutput("count_l_after_reset", int'(bus.count_l), 0);
      for (int p = 0; p < 260; p++) begin
         applyStimulus(mk(1'b1, 1'b0, 1'b1, 1'b0, 19, 1'b1, 1'b0));
         applyStimulus(mk(1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0));
         applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b0, 20, 1'b0, 1'b0));
         if (p == 0) checkOutput("count_l_first", int'(bus.count_l), 1);
         if (p == 99) checkOutput("count_l_100", int'(bus.count_l), 100);
      end
      checkOutput("count_l_saturated", int'(bus.count_l), 255);
      checkOutput("count_r_zero", int'(bus.count_r), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
